// File: rtl/store_monitor.sv
// Observes the processor store bus: queues in-window stores for a valid/ready drain port
// and runs a pass/fail/timeout verdict machine keyed on a completion store.
module store_monitor #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] ADDR_LO   = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI   = 32'hFFFF_FFFF,
    parameter logic [31:0] DONE_ADR  = 32'd100,
    parameter logic [31:0] DONE_DATA = 32'd25,
    parameter int          TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MemWrite,
    input  logic [31:0]                  DataAdr,
    input  logic [31:0]                  WriteData,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_adr,
    output logic [31:0]                  out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2,
        ST_TMO  = 2'd3
    } state_t;

    logic [63:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          out_valid_r;
    logic [31:0]   out_adr_r;
    logic [31:0]   out_data_r;
    logic          overflow_r;
    state_t        state_r;
    logic [TW-1:0] cyc_r;
    logic          done_r;
    logic          pass_r;
    logic          fail_r;
    logic          timeout_r;

    logic [32:0]   lo_diff_s;
    logic [32:0]   hi_diff_s;
    logic          cap_s;
    logic          pop_s;
    logic          full_s;
    logic          wr_en_s;
    logic          drop_s;
    logic [PW-1:0] rd_next_s;
    logic [CW-1:0] remain_s;
    logic [CW-1:0] count_next_s;
    logic [63:0]   head_s;
    logic          hit_s;
    state_t        state_next_s;
    logic [TW-1:0] cyc_next_s;

    // Capture window (borrow-based unsigned compare), FIFO bookkeeping and next head.
    always_comb begin
        lo_diff_s = {1'b0, DataAdr} - {1'b0, ADDR_LO};
        hi_diff_s = {1'b0, ADDR_HI} - {1'b0, DataAdr};
        cap_s     = MemWrite && !lo_diff_s[32] && !hi_diff_s[32];
        pop_s     = out_valid_r && out_ready;
        full_s    = (count_r == CW'(DEPTH));
        wr_en_s   = cap_s && (!full_s || pop_s);
        drop_s    = cap_s && full_s && !pop_s;
        if (pop_s) begin
            rd_next_s = rd_ptr_r + PW'(1);
        end else begin
            rd_next_s = rd_ptr_r;
        end
        remain_s     = count_r - {{(CW-1){1'b0}}, pop_s};
        count_next_s = remain_s + {{(CW-1){1'b0}}, wr_en_s};
        // When nothing older survives the pop, the incoming store becomes the head directly.
        if (remain_s != {CW{1'b0}}) begin
            head_s = mem_r[rd_next_s];
        end else if (wr_en_s) begin
            head_s = {DataAdr, WriteData};
        end else begin
            head_s = 64'h0;
        end
    end

    // Verdict machine next state; a completion store outranks timeout in the same cycle.
    always_comb begin
        hit_s        = MemWrite && (DataAdr == DONE_ADR);
        state_next_s = state_r;
        cyc_next_s   = cyc_r;
        case (state_r)
            ST_RUN: begin
                if (hit_s) begin
                    if (WriteData == DONE_DATA) begin
                        state_next_s = ST_PASS;
                    end else begin
                        state_next_s = ST_FAIL;
                    end
                end else if (cyc_r == TW'(TIMEOUT - 1)) begin
                    state_next_s = ST_TMO;
                end else begin
                    cyc_next_s = cyc_r + TW'(1);
                end
            end
            default: begin
                state_next_s = state_r;
                cyc_next_s   = cyc_r;
            end
        endcase
    end

    // Entry storage; stale contents are unreachable after reset because the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {DataAdr, WriteData};
        end
    end

    // FIFO pointers, occupancy, registered head and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            out_adr_r   <= 32'h0;
            out_data_r  <= 32'h0;
            overflow_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            rd_ptr_r    <= rd_next_s;
            count_r     <= count_next_s;
            out_valid_r <= (count_next_s != {CW{1'b0}});
            out_adr_r   <= head_s[63:32];
            out_data_r  <= head_s[31:0];
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Verdict state, saturating cycle counter and one-hot verdict flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_RUN;
            cyc_r     <= {TW{1'b0}};
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            fail_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cyc_r     <= cyc_next_s;
            done_r    <= (state_next_s != ST_RUN);
            pass_r    <= (state_next_s == ST_PASS);
            fail_r    <= (state_next_s == ST_FAIL);
            timeout_r <= (state_next_s == ST_TMO);
        end
    end

    assign out_valid = out_valid_r;
    assign out_adr   = out_adr_r;
    assign out_data  = out_data_r;
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign fail      = fail_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor: a queue scoreboard predicts drained stores and a
// small verdict model predicts pass/fail/timeout; every cycle is checked at the falling edge.
module tb_store_monitor;

    localparam int          DEPTH = 8;
    localparam logic [31:0] LO    = 32'h0000_0010;
    localparam logic [31:0] HI    = 32'h0000_0FFF;
    localparam int          TMO   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_adr;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        overflow;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;

    store_monitor #(
        .DEPTH(DEPTH), .ADDR_LO(LO), .ADDR_HI(HI),
        .DONE_ADR(32'd100), .DONE_DATA(32'd25), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .out_valid(out_valid), .out_ready(out_ready),
        .out_adr(out_adr), .out_data(out_data), .count(count), .overflow(overflow),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb [$];
    logic        ovf_m = 1'b0;
    int          st_m = 0;
    int          cyc_m = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   64'(out_valid), 64'(sb.size() != 0));
        chk({tag, ".count"},   64'(count),     64'(sb.size()));
        chk({tag, ".ovf"},     64'(overflow),  64'(ovf_m));
        chk({tag, ".done"},    64'(done),      64'(st_m != 0));
        chk({tag, ".pass"},    64'(pass),      64'(st_m == 1));
        chk({tag, ".fail"},    64'(fail),      64'(st_m == 2));
        chk({tag, ".timeout"}, 64'(timeout),   64'(st_m == 3));
        if (sb.size() != 0) begin
            chk({tag, ".head"}, {out_adr, out_data}, sb[0]);
        end
    endtask

    // Called at a falling edge: drive one cycle, update the model at the rising edge, check.
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic rdy, input string tag);
        bit pop_m;
        bit cap_m;
        bit hit_m;
        MemWrite  = we;
        DataAdr   = a;
        WriteData = d;
        out_ready = rdy;
        pop_m = rdy && (sb.size() != 0);
        cap_m = we && (a >= LO) && (a <= HI);
        hit_m = we && (a == 32'd100);
        @(posedge clk);
        if (pop_m) void'(sb.pop_front());
        if (cap_m) begin
            if (sb.size() < DEPTH) sb.push_back({a, d});
            else ovf_m = 1'b1;
        end
        if (st_m == 0) begin
            if (hit_m) st_m = (d == 32'd25) ? 1 : 2;
            else if (cyc_m == TMO - 1) st_m = 3;
            else cyc_m++;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2 * DEPTH + 4 && sb.size() != 0; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, tag);
        end
        chk({tag, ".empty"}, 64'(count), 64'd0);
    endtask

    // Called at a falling edge; asserts reset, checks async clearing, releases at the next falling edge.
    task automatic do_reset(input string tag);
        reset     = 1'b0;
        MemWrite  = 1'b0;
        out_ready = 1'b0;
        #2;
        sb.delete();
        ovf_m = 1'b0;
        st_m  = 0;
        cyc_m = 0;
        check_all(tag);
        chk({tag, ".adr"},  64'(out_adr),  64'd0);
        chk({tag, ".data"}, 64'(out_data), 64'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // T1: power-on reset held 22 ns
        #10;
        check_all("T1.rst");
        chk("T1.adr",  64'(out_adr),  64'd0);
        chk("T1.data", 64'(out_data), 64'd0);
        #12;
        reset = 1'b1;
        @(negedge clk);
        check_all("T1.rel");
        idle(2, "T1.idle");

        // T2: single store held until ready, then popped
        cycle(1'b1, 32'd84, 32'd7, 1'b0, "T2.st");
        chk("T2.adr",  64'(out_adr),  64'd84);
        chk("T2.data", 64'(out_data), 64'd7);
        idle(3, "T2.hold");
        cycle(1'b0, 32'h0, 32'h0, 1'b1, "T2.pop");

        // Window edges: just outside and exactly on each bound
        cycle(1'b1, 32'h0000_000F, 32'd1, 1'b0, "WIN.below");
        cycle(1'b1, 32'h0000_1000, 32'd2, 1'b0, "WIN.above");
        cycle(1'b1, 32'h0000_0010, 32'd3, 1'b0, "WIN.lo");
        cycle(1'b1, 32'h0000_0FFF, 32'd4, 1'b0, "WIN.hi");
        chk("WIN.count", 64'(count), 64'd2);
        drain("WIN.drain");

        // T3/T4: fill, store+pop while full, then an overflowing store, then drain in order
        do_reset("T3.rst");
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'd200 + 32'(4 * i), 32'(i + 1), 1'b0, "T3.fill");
        chk("T3.full", 64'(count), 64'd8);
        cycle(1'b1, 32'd300, 32'd55, 1'b1, "T4.stpop");
        chk("T4.count", 64'(count),    64'd8);
        chk("T4.ovf",   64'(overflow), 64'd0);
        cycle(1'b1, 32'd400, 32'd66, 1'b0, "T3.drop");
        chk("T3.ovf", 64'(overflow), 64'd1);
        drain("T3.drain");
        idle(1, "T3.sticky");

        // Reset in the middle of a partly filled FIFO
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'd500 + 32'(i), 32'(i), 1'b0, "MID.fill");
        do_reset("MID.rst");
        idle(2, "MID.after");

        // T5: pass, later completion store ignored
        do_reset("T5.rst");
        cycle(1'b1, 32'd100, 32'd25, 1'b0, "T5.pass");
        chk("T5.passflag", 64'(pass), 64'd1);
        cycle(1'b1, 32'd100, 32'd3, 1'b0, "T5.late");
        chk("T5.stay", 64'({pass, fail}), 64'b10);
        drain("T5.drain");

        // T6: fail
        do_reset("T6.rst");
        cycle(1'b1, 32'd100, 32'd24, 1'b0, "T6.fail");
        chk("T6.failflag", 64'(fail), 64'd1);

        // T6: timeout exactly after TIMEOUT cycles, then a completion store is ignored
        do_reset("TMO.rst");
        idle(TMO - 1, "TMO.wait");
        chk("TMO.early", 64'(timeout), 64'd0);
        idle(1, "TMO.edge");
        chk("TMO.hit", 64'(timeout), 64'd1);
        cycle(1'b1, 32'd100, 32'd25, 1'b0, "TMO.late");
        chk("TMO.nopass", 64'(pass), 64'd0);

        // Completion store on the timeout cycle wins
        do_reset("TIE.rst");
        idle(TMO - 1, "TIE.wait");
        cycle(1'b1, 32'd100, 32'd25, 1'b0, "TIE.st");
        chk("TIE.flags", 64'({pass, timeout}), 64'b10);
        drain("TIE.drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
